// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage RV32 pipeline (F, D, E, M, W).
// Merges load-use, taken-branch, multi-cycle memory and multi-cycle MUL/DIV
// requests into one prioritised set of StallX/FlushX controls. An FSM holds
// the pipeline across multi-cycle waits; a watchdog forces release of a stuck
// memory access and raises a sticky TimeoutErr.
// Optional feature macro: STALL_PERF_CNT_EN adds the StallCycles/FlushEvents
// saturating performance counters.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LoadUseHazD,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic              MduStartE,
  input  logic              MduDoneE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        CtrlState,
`ifdef STALL_PERF_CNT_EN
  output logic [PERF_W-1:0] StallCycles,
  output logic [PERF_W-1:0] FlushEvents,
`endif
  output logic              TimeoutErr
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_MDU_WAIT = 2'b10
  } state_e;

  // Reject configurations the watchdog cannot represent.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > (2 ** TO_W) - 1 || PERF_W < 1) begin : g_bad_param
    $error("pipeline_stall_controller: illegal MEM_TIMEOUT/TO_W/PERF_W combination");
  end

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_ZERO  = {TO_W{1'b0}};

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            terr_q, terr_d;

  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic flush_d_s, flush_e_s, flush_m_s, flush_w_s;

  // Next-state, watchdog and raw control decode from state plus hazard inputs.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    terr_d    = terr_q;
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_m_s = 1'b0;
    flush_w_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        to_cnt_d = TO_ZERO;
        if (MemReqM && !MemReadyM) begin
          // Freeze F..M, let W drain with a bubble while memory is busy.
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          stall_e_s = 1'b1;
          stall_m_s = 1'b1;
          flush_w_s = 1'b1;
          state_d   = ST_MEM_WAIT;
          to_cnt_d  = TO_ONE;
        end else if (MduStartE && !MduDoneE) begin
          // Freeze F..E, push bubbles into M while the MDU iterates.
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          stall_e_s = 1'b1;
          flush_m_s = 1'b1;
          state_d   = ST_MDU_WAIT;
        end else if (BranchTakenE) begin
          // Wrong-path instructions in D and E are squashed; any load-use
          // hazard they raise is irrelevant.
          flush_d_s = 1'b1;
          flush_e_s = 1'b1;
        end else if (LoadUseHazD) begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          flush_e_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (MemReadyM) begin
          state_d  = ST_RUN;
          to_cnt_d = TO_ZERO;
        end else if (to_cnt_q >= TO_LIMIT) begin
          // Watchdog: give up on the access so the core cannot hang forever.
          terr_d   = 1'b1;
          state_d  = ST_RUN;
          to_cnt_d = TO_ZERO;
        end else begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          stall_e_s = 1'b1;
          stall_m_s = 1'b1;
          flush_w_s = 1'b1;
          if (to_cnt_q != {TO_W{1'b1}}) begin
            to_cnt_d = to_cnt_q + TO_ONE;
          end else begin
            to_cnt_d = to_cnt_q;
          end
        end
      end
      ST_MDU_WAIT: begin
        if (MduDoneE) begin
          state_d = ST_RUN;
        end else begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          stall_e_s = 1'b1;
          flush_m_s = 1'b1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        to_cnt_d = TO_ZERO;
      end
    endcase
  end

  // State, watchdog counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      to_cnt_q <= TO_ZERO;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end

  // Controls are forced quiet while reset is held, even if state is stale.
  always_comb begin
    StallF    = stall_f_s & ~reset;
    StallD    = stall_d_s & ~reset;
    StallE    = stall_e_s & ~reset;
    StallM    = stall_m_s & ~reset;
    FlushD    = flush_d_s & ~reset;
    FlushE    = flush_e_s & ~reset;
    FlushM    = flush_m_s & ~reset;
    FlushW    = flush_w_s & ~reset;
    CtrlState = reset ? 2'b00 : state_q;
  end

  assign TimeoutErr = terr_q;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [PERF_W-1:0] flush_ev_q, flush_ev_d;

  // Saturating counters of fetch-stall cycles and decode-flush cycles.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_ev_d  = flush_ev_q;
    if (StallF && (stall_cyc_q != {PERF_W{1'b1}})) begin
      stall_cyc_d = stall_cyc_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cyc_d = stall_cyc_q;
    end
    if (FlushD && (flush_ev_q != {PERF_W{1'b1}})) begin
      flush_ev_d = flush_ev_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      flush_ev_d = flush_ev_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q <= {PERF_W{1'b0}};
      flush_ev_q  <= {PERF_W{1'b0}};
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_ev_q  <= flush_ev_d;
    end
  end

  assign StallCycles = stall_cyc_q;
  assign FlushEvents = flush_ev_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: table-driven per-cycle vectors with
// a scoreboard queue, plus hand-written reset-mid-wait and watchdog sequences.
// DUT built with MEM_TIMEOUT=4 so the watchdog fires quickly.
module tb_pipeline_stall_controller;

  localparam int PERF_W = 32;

  logic clk = 1'b0;
  logic reset, LoadUseHazD, BranchTakenE, MemReqM, MemReadyM, MduStartE, MduDoneE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] CtrlState;
  logic TimeoutErr;
`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] StallCycles, FlushEvents;
`endif

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .TO_W(8), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .LoadUseHazD(LoadUseHazD), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .MduStartE(MduStartE), .MduDoneE(MduDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .CtrlState(CtrlState),
`ifdef STALL_PERF_CNT_EN
    .StallCycles(StallCycles), .FlushEvents(FlushEvents),
`endif
    .TimeoutErr(TimeoutErr)
  );

  // inputs: {reset, LoadUseHazD, BranchTakenE, MemReqM, MemReadyM, MduStartE, MduDoneE}
  // stall : {StallF, StallD, StallE, StallM}; flush: {FlushD, FlushE, FlushM, FlushW}
  typedef struct packed {
    logic [6:0] in;
    logic [3:0] stall;
    logic [3:0] flush;
    logic [1:0] st;
    logic       chk_terr;
    logic       terr;
  } vec_t;

  localparam logic [3:0] S_NONE = 4'b0000, F_NONE = 4'b0000;
  localparam logic [3:0] S_MEM = 4'b1111, F_MEM = 4'b0001;
  localparam logic [3:0] S_MDU = 4'b1110, F_MDU = 4'b0010;
  localparam logic [3:0] S_LU  = 4'b1100, F_LU  = 4'b0100;
  localparam logic [3:0] F_BR  = 4'b1100;

  vec_t table_q[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic [6:0] in, input logic [3:0] s, input logic [3:0] f,
                              input logic [1:0] st, input logic ct, input logic t);
    vec_t v;
    v.in = in; v.stall = s; v.flush = f; v.st = st; v.chk_terr = ct; v.terr = t;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(input vec_t v);
    vec_t e;
    logic [9:0] got, want;
    @(posedge clk);
    #1;
    {reset, LoadUseHazD, BranchTakenE, MemReqM, MemReadyM, MduStartE, MduDoneE} = v.in;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    got  = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, CtrlState};
    want = {e.stall, e.flush, e.st};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL ctrl step %0d: got stall=%b flush=%b state=%b, want stall=%b flush=%b state=%b",
               step_no, got[9:6], got[5:2], got[1:0], e.stall, e.flush, e.st);
    end
    if (e.chk_terr) begin
      checks++;
      if (TimeoutErr !== e.terr) begin
        errors++;
        $display("FAIL terr step %0d: got %b want %b", step_no, TimeoutErr, e.terr);
      end
    end
    step_no++;
  endtask

  task automatic check_val(input string name, input logic [PERF_W-1:0] got,
                           input logic [PERF_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // M holds bubbles during an MDU wait, so the stimulus must never request memory there.
  always @(negedge clk) begin
    if (reset === 1'b0 && CtrlState === 2'b10) begin
      assert (MemReqM === 1'b0) else $error("MemReqM driven during MDU_WAIT");
    end
  end

  initial begin
    {reset, LoadUseHazD, BranchTakenE, MemReqM, MemReadyM, MduStartE, MduDoneE} = 7'b1000000;
    repeat (2) @(posedge clk);

    // reset / basic priorities
    table_q.push_back(mk(7'b1000000, S_NONE, F_NONE, 2'b00, 1'b1, 1'b0));
    table_q.push_back(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b1, 1'b0));
    table_q.push_back(mk(7'b0100000, S_LU,   F_LU,   2'b00, 1'b1, 1'b0)); // load-use
    table_q.push_back(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0)); // one cycle only
    table_q.push_back(mk(7'b0110000, S_NONE, F_BR,   2'b00, 1'b0, 1'b0)); // branch beats load-use
    table_q.push_back(mk(7'b0010000, S_NONE, F_BR,   2'b00, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0001100, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0)); // single-cycle mem
    table_q.push_back(mk(7'b0000011, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0)); // single-cycle mdu
    table_q.push_back(mk(7'b0011010, S_MEM,  F_MEM,  2'b00, 1'b0, 1'b0)); // mem beats mdu/branch
    table_q.push_back(mk(7'b0001100, S_NONE, F_NONE, 2'b01, 1'b0, 1'b0)); // ready at once
    table_q.push_back(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0110010, S_MDU,  F_MDU,  2'b00, 1'b0, 1'b0)); // mdu beats branch
    table_q.push_back(mk(7'b0000010, S_MDU,  F_MDU,  2'b10, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0110010, S_MDU,  F_MDU,  2'b10, 1'b0, 1'b0)); // ignored in wait
    table_q.push_back(mk(7'b0000011, S_NONE, F_NONE, 2'b10, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0));
    // memory wait: 3 stalled cycles, then ready
    table_q.push_back(mk(7'b0001000, S_MEM,  F_MEM,  2'b00, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0001000, S_MEM,  F_MEM,  2'b01, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0111000, S_MEM,  F_MEM,  2'b01, 1'b0, 1'b0)); // branch/lu ignored
    table_q.push_back(mk(7'b0001100, S_NONE, F_NONE, 2'b01, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0010000, S_NONE, F_BR,   2'b00, 1'b0, 1'b0)); // branch after release
    table_q.push_back(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0));
    // MDU: 5 stalled cycles, release in done cycle
    table_q.push_back(mk(7'b0000010, S_MDU,  F_MDU,  2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++)
      table_q.push_back(mk(7'b0000010, S_MDU, F_MDU, 2'b10, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0000011, S_NONE, F_NONE, 2'b10, 1'b0, 1'b0));
    table_q.push_back(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b1, 1'b0));

    for (int i = 0; i < table_q.size(); i++) step(table_q[i]);

    // reset in the middle of a memory wait
    step(mk(7'b0001000, S_MEM,  F_MEM,  2'b00, 1'b1, 1'b0));
    step(mk(7'b0001000, S_MEM,  F_MEM,  2'b01, 1'b1, 1'b0));
    step(mk(7'b1001000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0));
    step(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b1, 1'b0));
`ifdef STALL_PERF_CNT_EN
    check_val("stall_cycles_after_reset", StallCycles, '0);
    check_val("flush_events_after_reset", FlushEvents, '0);
    step(mk(7'b0100000, S_LU,   F_LU,   2'b00, 1'b0, 1'b0));
    step(mk(7'b0010000, S_NONE, F_BR,   2'b00, 1'b0, 1'b0));
    step(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0));
    check_val("stall_cycles_count", StallCycles, 32'd1);
    check_val("flush_events_count", FlushEvents, 32'd1);
`endif

    // watchdog: ready never comes, 4 stalled cycles then forced release
    step(mk(7'b0001000, S_MEM,  F_MEM,  2'b00, 1'b1, 1'b0));
    step(mk(7'b0001000, S_MEM,  F_MEM,  2'b01, 1'b1, 1'b0));
    step(mk(7'b0001000, S_MEM,  F_MEM,  2'b01, 1'b1, 1'b0));
    step(mk(7'b0001000, S_MEM,  F_MEM,  2'b01, 1'b1, 1'b0));
    step(mk(7'b0001000, S_NONE, F_NONE, 2'b01, 1'b0, 1'b0));
    step(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b1, 1'b1));
    step(mk(7'b0001100, S_NONE, F_NONE, 2'b00, 1'b1, 1'b1)); // sticky
    step(mk(7'b1000000, S_NONE, F_NONE, 2'b00, 1'b0, 1'b0));
    step(mk(7'b0000000, S_NONE, F_NONE, 2'b00, 1'b1, 1'b0)); // cleared by reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
